// File: rtl/mux_test_pkg.sv
// Shared definitions for the mux2to1 stimulus/checker block.
// Holds the FSM state encoding, the size of one exhaustive sweep of the
// mux's three inputs, and the golden mux function the checker compares
// against. Ports: none.
package mux_test_pkg;

    // FSM state encoding for the sweep controller
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // One sweep covers every {s,a1,a0} combination
    localparam int NUM_VEC = 8;

    // Golden 2:1 mux: vec = {s, a1, a0}, returns s ? a1 : a0
    function automatic logic mux_ref(input logic [2:0] vec);
        return vec[2] ? vec[1] : vec[0];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the mismatch count.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, count -> 0
//   clr    in   synchronous clear (wins over inc)
//   inc    in   increment request; ignored once the count is all ones
//   count  out  W-bit registered count
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = W'(1);

    // Count register: clear has priority, increment stops at all ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= CNT_ZERO;
        end else if (clr) begin
            count <= CNT_ZERO;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/mux_stim_checker.sv
// Self-running vector sequencer and checker for a mux2to1.
// On an accepted start it drives all eight {s,a1,a0} combinations LOOPS
// times, holds each for SETTLE_CYCLES+1 cycles, samples t_i on the last
// cycle of each vector and compares it against s ? a1 : a0.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               run request (ignored while busy)
//   s_o, a1_o, a0_o     registered stimulus to the mux under test
//   t_i                 mux output fed back (same clock domain)
//   busy, done, pass    run status; pass is valid while done=1
//   err_count           saturating mismatch count
//   first_fail          {s,a1,a0} of the first mismatch of the run, 0 if none
//   vec_idx             current vector index
module mux_stim_checker
    import mux_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             s_o,
    output logic             a1_o,
    output logic             a0_o,
    input  logic             t_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       first_fail,
    output logic [2:0]       vec_idx
);

    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LOOP_LAST     = 8'(LOOPS - 1);
    localparam logic [2:0] VEC_LAST      = 3'(NUM_VEC - 1);

    state_t     state_r, state_s;
    logic [3:0] settle_r, settle_s;
    logic [7:0] loop_r, loop_s;
    logic [2:0] vec_r, vec_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       pass_r, pass_s;
    logic [2:0] ff_r, ff_s;
    logic       err_inc_s;
    logic       err_clr_s;
    logic       mismatch_s;
    logic       no_err_s;

    // Mismatch counter; cleared on every accepted start
    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (err_clr_s),
        .inc   (err_inc_s),
        .count (err_count)
    );

    // Next-state and next-register logic for the sweep controller
    always_comb begin
        state_s    = state_r;
        settle_s   = settle_r;
        loop_s     = loop_r;
        vec_s      = vec_r;
        busy_s     = busy_r;
        done_s     = done_r;
        pass_s     = pass_r;
        ff_s       = ff_r;
        err_inc_s  = 1'b0;
        err_clr_s  = 1'b0;
        mismatch_s = (t_i != mux_ref(vec_r));
        // err_count==0 means no mismatch yet this run, even after saturation
        no_err_s   = (err_count == {ERR_W{1'b0}});

        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s   = SETTLE;
                    busy_s    = 1'b1;
                    done_s    = 1'b0;
                    pass_s    = 1'b0;
                    err_clr_s = 1'b1;
                    ff_s      = 3'd0;
                    vec_s     = 3'd0;
                    loop_s    = 8'd0;
                    settle_s  = SETTLE_RELOAD;
                end else begin
                    state_s = state_r;
                end
            end
            SETTLE: begin
                if (settle_r == 4'd0) begin
                    state_s = CHECK;
                end else begin
                    settle_s = settle_r - 4'd1;
                end
            end
            CHECK: begin
                if (mismatch_s) begin
                    err_inc_s = 1'b1;
                    if (no_err_s) begin
                        ff_s = vec_r;
                    end else begin
                        ff_s = ff_r;
                    end
                end else begin
                    err_inc_s = 1'b0;
                end

                if (vec_r != VEC_LAST) begin
                    vec_s    = vec_r + 3'd1;
                    settle_s = SETTLE_RELOAD;
                    state_s  = SETTLE;
                end else if (loop_r != LOOP_LAST) begin
                    vec_s    = 3'd0;
                    loop_s   = loop_r + 8'd1;
                    settle_s = SETTLE_RELOAD;
                    state_s  = SETTLE;
                end else begin
                    state_s = DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    // Include a mismatch found on this final check
                    pass_s  = no_err_s && !mismatch_s;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            settle_r <= 4'd0;
            loop_r   <= 8'd0;
            vec_r    <= 3'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            ff_r     <= 3'd0;
        end else begin
            state_r  <= state_s;
            settle_r <= settle_s;
            loop_r   <= loop_s;
            vec_r    <= vec_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            pass_r   <= pass_s;
            ff_r     <= ff_s;
        end
    end

    // Stimulus bits come straight from the vector register, so they move
    // only on the edge that advances the vector
    assign s_o        = vec_r[2];
    assign a1_o       = vec_r[1];
    assign a0_o       = vec_r[0];
    assign vec_idx    = vec_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign first_fail = ff_r;

endmodule

// File: tb/tb_mux_stim_checker.sv
// Bench for mux_stim_checker: three instances (defaults; ERR_W=2;
// LOOPS=2/SETTLE_CYCLES=1) each fed by an emulated mux whose behaviour
// is selectable (correct, stuck at 0, inverted). A cycle-level model
// based on elapsed time since start predicts every output.
module tb_mux_stim_checker;

    localparam int        SC_P  [3] = '{2, 2, 1};
    localparam int        L_P   [3] = '{1, 1, 2};
    localparam int        MAX_P [3] = '{15, 3, 15};
    localparam logic [7:0] REF_T    = 8'b1100_1010; // expected t indexed by {s,a1,a0}

    logic clk = 1'b0;
    logic rst_n;
    logic st [3];
    int   mode [3];

    logic       o_s [3], o_a1 [3], o_a0 [3], o_t [3];
    logic       o_bz [3], o_dn [3], o_ps [3];
    logic [2:0] o_ff [3], o_vi [3];
    logic [3:0] ec_a, ec_c;
    logic [1:0] ec_b;
    int         o_ec [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Mux under test: 0 = correct, 1 = stuck at 0, 2 = inverted
    function automatic logic tmux(input int md, input logic [2:0] v);
        logic good;
        good = v[2] ? v[1] : v[0];
        if (md == 1) return 1'b0;
        if (md == 2) return ~good;
        return good;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) o_t[i] = tmux(mode[i], {o_s[i], o_a1[i], o_a0[i]});
        o_ec[0] = int'(ec_a);
        o_ec[1] = int'(ec_b);
        o_ec[2] = int'(ec_c);
    end

    mux_stim_checker u_a (
        .clk(clk), .rst_n(rst_n), .start(st[0]),
        .s_o(o_s[0]), .a1_o(o_a1[0]), .a0_o(o_a0[0]), .t_i(o_t[0]),
        .busy(o_bz[0]), .done(o_dn[0]), .pass(o_ps[0]),
        .err_count(ec_a), .first_fail(o_ff[0]), .vec_idx(o_vi[0])
    );

    mux_stim_checker #(.ERR_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st[1]),
        .s_o(o_s[1]), .a1_o(o_a1[1]), .a0_o(o_a0[1]), .t_i(o_t[1]),
        .busy(o_bz[1]), .done(o_dn[1]), .pass(o_ps[1]),
        .err_count(ec_b), .first_fail(o_ff[1]), .vec_idx(o_vi[1])
    );

    mux_stim_checker #(.SETTLE_CYCLES(1), .LOOPS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(st[2]),
        .s_o(o_s[2]), .a1_o(o_a1[2]), .a0_o(o_a0[2]), .t_i(o_t[2]),
        .busy(o_bz[2]), .done(o_dn[2]), .pass(o_ps[2]),
        .err_count(ec_c), .first_fail(o_ff[2]), .vec_idx(o_vi[2])
    );

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d", nm, idx, $time, act, exp);
        end
    endtask

    // Model state: elapsed cycles since the accepted start drive everything
    logic       m_run [3], m_dn [3], m_ps [3];
    int         m_e [3], m_err [3];
    logic [2:0] m_ff [3], m_vec [3];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_run[i] <= 1'b0; m_dn[i] <= 1'b0; m_ps[i] <= 1'b0;
                m_e[i] <= 0; m_err[i] <= 0; m_ff[i] <= 3'd0; m_vec[i] <= 3'd0;
            end else if (!m_run[i]) begin
                if (st[i]) begin
                    m_run[i] <= 1'b1; m_dn[i] <= 1'b0; m_ps[i] <= 1'b0;
                    m_e[i] <= 0; m_err[i] <= 0; m_ff[i] <= 3'd0; m_vec[i] <= 3'd0;
                end
            end else begin : step
                int p, e1, ne, v;
                logic [2:0] ffv;
                p   = SC_P[i] + 1;
                e1  = m_e[i] + 1;
                ne  = m_err[i];
                ffv = m_ff[i];
                m_e[i] <= e1;
                if (e1 % p == 0) begin
                    v = (e1 / p - 1) % 8;
                    if (tmux(mode[i], 3'(v)) != REF_T[v]) begin
                        if (ne == 0) ffv = 3'(v);
                        if (ne < MAX_P[i]) ne++;
                    end
                    if (e1 == 8 * L_P[i] * p) begin
                        m_run[i] <= 1'b0;
                        m_dn[i]  <= 1'b1;
                        m_ps[i]  <= (ne == 0);
                    end else begin
                        m_vec[i] <= 3'((e1 / p) % 8);
                    end
                end
                m_err[i] <= ne;
                m_ff[i]  <= ffv;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk("busy", i, int'(o_bz[i]), int'(m_run[i]));
            chk("done", i, int'(o_dn[i]), int'(m_dn[i]));
            chk("pass", i, int'(o_ps[i]), int'(m_ps[i]));
            chk("err_count", i, o_ec[i], m_err[i]);
            chk("first_fail", i, int'(o_ff[i]), int'(m_ff[i]));
            chk("vec_idx", i, int'(o_vi[i]), int'(m_vec[i]));
            chk("stim", i, int'({o_s[i], o_a1[i], o_a0[i]}), int'(m_vec[i]));
        end
    end

    // Start a run on dut i; n = edges after the start edge until done (or -1 on reset abort)
    task automatic run(input int i, input int poke_at, input int rst_at, output int n);
        @(negedge clk);
        st[i] = 1'b1;
        @(posedge clk);
        #1 st[i] = 1'b0;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            st[i] = (n == poke_at);
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", i, int'(o_bz[i]), 0);
                chk("rst_vec", i, int'(o_vi[i]), 0);
                chk("rst_err", i, o_ec[i], 0);
                chk("rst_stim", i, int'({o_s[i], o_a1[i], o_a0[i]}), 0);
                n = -1;
                return;
            end
            if (o_dn[i]) return;
        end
        chk("timeout", i, n, 0);
    endtask

    initial begin
        int n;
        int rises [$];
        rst_n = 1'b0;
        st    = '{1'b0, 1'b0, 1'b0};
        mode  = '{0, 2, 0};
        repeat (3) @(negedge clk);
        chk("reset_done", 0, int'(o_dn[0]), 0);
        chk("reset_vec", 0, int'(o_vi[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct mux, defaults
        run(0, -1, -1, n);
        chk("t1_latency", 0, n, 24);
        chk("t1_pass", 0, int'(o_ps[0]), 1);
        chk("t1_err", 0, o_ec[0], 0);
        chk("t1_ff", 0, int'(o_ff[0]), 0);

        // t stuck at 0
        mode[0] = 1;
        run(0, -1, -1, n);
        chk("t2_latency", 0, n, 24);
        chk("t2_err", 0, o_ec[0], 4);
        chk("t2_ff", 0, int'(o_ff[0]), 1);
        chk("t2_pass", 0, int'(o_ps[0]), 0);

        // Inverted mux, 2-bit counter saturates
        run(1, -1, -1, n);
        chk("t3_latency", 1, n, 24);
        chk("t3_err", 1, o_ec[1], 3);
        chk("t3_ff", 1, int'(o_ff[1]), 0);
        chk("t3_pass", 1, int'(o_ps[1]), 0);

        // Two loops, short settle, stray start mid-run
        run(2, 10, -1, n);
        chk("t4_latency", 2, n, 32);
        chk("t4_pass", 2, int'(o_ps[2]), 1);

        // Reset mid-run, then a clean run
        mode[0] = 0;
        run(0, -1, 13, n);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(0, -1, -1, n);
        chk("t5_latency", 0, n, 24);
        chk("t5_err", 0, o_ec[0], 0);
        chk("t5_pass", 0, int'(o_ps[0]), 1);

        // Start held high: re-arm on every completion
        mode[0] = 1;
        @(negedge clk);
        st[0] = 1'b1;
        @(posedge clk);
        #1 n = 0;
        repeat (80) begin
            @(posedge clk);
            n++;
            #1;
            if (o_dn[0]) rises.push_back(n);
            if (n == 25) chk("t6_err_cleared", 0, o_ec[0], 0);
        end
        st[0] = 1'b0;
        chk("t6_done_count", 0, rises.size(), 3);
        if (rises.size() >= 3) begin
            chk("t6_done1", 0, rises[0], 24);
            chk("t6_done2", 0, rises[1], 49);
            chk("t6_done3", 0, rises[2], 74);
        end
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
